// File: rtl/vga_mode_sequencer.sv
// Display-mode sequencer: debounced push-button and optional frame-timed auto-cycle advance the mode only at frame boundaries.
// Optional feature macro: VGA_AUTO_CYCLE_EN (auto-cycle frame counter).
`timescale 1ns/1ps
module vga_mode_sequencer #(
  parameter int DEBOUNCE_CYCLES = 90000,
  parameter int NUM_MODES       = 14,
  parameter int AUTO_FRAMES     = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  input  logic       frame_start,
  input  logic       auto_en,
  output logic [3:0] mode,
  output logic       mode_stb,
  output logic       pending
);

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_e;

  localparam logic [19:0] DEB_MAX   = 20'(DEBOUNCE_CYCLES);
  localparam logic [19:0] DEB_LAST  = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]  MODE_LAST = 4'(NUM_MODES - 1);
  localparam logic [11:0] AUTO_LAST = 12'(AUTO_FRAMES - 1);

  logic [1:0]  rst_sync_q;
  logic        rst_hold_s;
  logic [1:0]  key_sync_q;
  logic        key_s;
  logic [19:0] deb_cnt_q;
  logic        press_s;
  logic        tick_s;
  state_e      state_q, state_d;
  logic [3:0]  mode_q, mode_d;
  logic        stb_q, stb_d;

  // Assertion is immediate; release reaches the logic two clock edges later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync_q <= 2'b11;
    else     rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst_hold_s = rst_sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             key_sync_q <= 2'b11;
    else if (rst_hold_s) key_sync_q <= 2'b11;
    else                 key_sync_q <= {key_sync_q[0], key_n};
  end
  assign key_s = key_sync_q[1];

  // Counter saturates at DEBOUNCE_CYCLES so the press compare matches once per hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       deb_cnt_q <= 20'd0;
    else if (rst_hold_s)           deb_cnt_q <= 20'd0;
    else if (key_s)                deb_cnt_q <= 20'd0;
    else if (deb_cnt_q < DEB_MAX)  deb_cnt_q <= deb_cnt_q + 20'd1;
    else                           deb_cnt_q <= deb_cnt_q;
  end
  assign press_s = !key_s && (deb_cnt_q == DEB_LAST);

`ifdef VGA_AUTO_CYCLE_EN
  logic [11:0] frame_cnt_q;

  assign tick_s = auto_en && frame_start && (state_q == IDLE) && (frame_cnt_q == AUTO_LAST);

  // Dwell counter only runs in IDLE, so the applying frame is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                frame_cnt_q <= 12'd0;
    else if (rst_hold_s)                    frame_cnt_q <= 12'd0;
    else if (!auto_en || press_s)           frame_cnt_q <= 12'd0;
    else if (frame_start && state_q == IDLE) frame_cnt_q <= tick_s ? 12'd0 : frame_cnt_q + 12'd1;
    else                                    frame_cnt_q <= frame_cnt_q;
  end
`else
  logic [11:0] auto_unused;

  assign tick_s      = 1'b0;
  assign auto_unused = AUTO_LAST ^ {11'd0, auto_en};
`endif

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    stb_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_s || tick_s) state_d = PENDING;
        else                   state_d = IDLE;
      end
      PENDING: begin
        if (frame_start) begin
          state_d = IDLE;
          mode_d  = (mode_q == MODE_LAST) ? 4'd0 : mode_q + 4'd1;
          stb_d   = 1'b1;
        end else begin
          state_d = PENDING;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 4'd0;
      stb_q   <= 1'b0;
    end else if (rst_hold_s) begin
      state_q <= IDLE;
      mode_q  <= 4'd0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      stb_q   <= stb_d;
    end
  end

  assign mode     = mode_q;
  assign mode_stb = stb_q;
  assign pending  = (state_q == PENDING);

endmodule
